// File: rtl/frame_reader_pkg.sv
// Shared definitions for the display-side frame reader and the processing
// stage that fills the ping-pong buffers.
package frame_reader_pkg;

  // Reader control states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    REQ   = 3'd2,
    BURST = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Ping-pong buffer base word addresses
  localparam int unsigned BUF0_BASE = 32'd4147200;  // written while image_addr_flag=1
  localparam int unsigned BUF1_BASE = 32'd6220800;  // written while image_addr_flag=0

  // Width of the burst-length field on the memory request channel
  typedef logic [9:0] burst_len_t;

endpackage

// File: rtl/frame_reader_if.sv
// Memory read channel plus pixel output stream of the frame reader.
//
// Handshakes:
//   Read channel: rd_valid/rd_addr are held stable from the request until
//   the cycle after rd_burst_finish. Each cycle with rd_ready=1 carries one
//   beat on rd_data. rd_burst_finish is a one-cycle pulse ending the burst.
//   Output stream: a word moves on every clock edge where out_valid and
//   out_ready are both high; out_data/out_sof/out_eol are stable while
//   out_valid is high and out_ready is low.
interface frame_reader_if
  import frame_reader_pkg::*;
#(
  parameter int MEM_DATA_LEN = 64,
  parameter int ADDR_LEN     = 32
);
  logic                    rd_valid;
  logic                    rd_ready;
  burst_len_t              rd_burst_len;
  logic [ADDR_LEN-1:0]     rd_addr;
  logic [MEM_DATA_LEN-1:0] rd_data;
  logic                    rd_burst_finish;
  logic                    out_valid;
  logic                    out_ready;
  logic [MEM_DATA_LEN-1:0] out_data;
  logic                    out_sof;
  logic                    out_eol;

  // Reader side
  modport master (
    output rd_valid, rd_burst_len, rd_addr,
    input  rd_ready, rd_data, rd_burst_finish,
    output out_valid, out_data, out_sof, out_eol,
    input  out_ready
  );

  // Memory and video sink side
  modport slave (
    input  rd_valid, rd_burst_len, rd_addr,
    output rd_ready, rd_data, rd_burst_finish,
    input  out_valid, out_data, out_sof, out_eol,
    output out_ready
  );
endinterface

// File: rtl/frame_reader_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and occupancy count.
// The head word is visible on o_rd_data whenever the FIFO is non-empty and
// reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Flush takes priority over any write or read in the same cycle
  assign w_wr = i_wr_en && !o_full && !i_flush;
  assign w_rd = i_rd_en && !o_empty && !i_flush;

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/frame_reader.sv
// Display-side frame buffer reader: picks the ping-pong buffer completed most
// recently, fetches it in bursts into a local FIFO, and streams it in raster
// order with start-of-frame and end-of-line markers.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int MEM_DATA_LEN = 64,
  parameter int ADDR_LEN     = 32,
  parameter int VIDEO_WIDTH  = 1024,
  parameter int VIDEO_HEIGHT = 768,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_image_addr_flag,
  input  logic           i_frame_start,
  frame_reader_if.master bus,
  output logic           o_underrun,
  output logic           o_error,
  output state_t         o_state
);
  localparam int FRAME_WORDS = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int CW          = $clog2(FRAME_WORDS) + 1;
  localparam int FAW         = $clog2(FIFO_DEPTH);
  // A burst may be requested only while the FIFO holds at most this many words
  localparam int ROOM_LIMIT  = FIFO_DEPTH - BURST_LEN;
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_X    = CW'(VIDEO_WIDTH - 1);
  localparam logic [CW-1:0] LAST_Y    = CW'(VIDEO_HEIGHT - 1);
  localparam burst_len_t    BURST_BL  = burst_len_t'(BURST_LEN);

  state_t              r_state;
  logic                r_rd_valid;
  logic [ADDR_LEN-1:0] r_rd_addr;
  logic [ADDR_LEN-1:0] r_base;
  logic [CW-1:0]       r_req_words;
  burst_len_t          r_beat_cnt;
  logic                r_restart_pend;
  logic                r_error;
  logic                r_underrun;
  logic [CW-1:0]       r_out_words;
  logic [CW-1:0]       r_x_out;
  logic [CW-1:0]       r_y_out;

  logic [MEM_DATA_LEN-1:0] w_fifo_data;
  logic [FAW:0]            w_fifo_count;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  logic                    w_fifo_wr;
  logic                    w_xfer;
  logic                    w_in_burst;
  logic                    w_restart;
  logic                    w_room;

  assign w_in_burst = (r_state == BURST);
  // A frame_start inside a burst waits for the burst to finish; elsewhere it
  // restarts at once.
  assign w_restart  = (i_frame_start && !w_in_burst) ||
                      (w_in_burst && bus.rd_burst_finish && (r_restart_pend || i_frame_start));
  // Beats are dropped once a restart is pending or past the burst length
  assign w_fifo_wr  = w_in_burst && bus.rd_ready && !r_restart_pend && !i_frame_start &&
                      (r_beat_cnt < BURST_BL) && !w_fifo_full;
  assign w_xfer     = !w_fifo_empty && bus.out_ready;
  // Nothing is in flight while in ARM, so occupancy alone bounds free space
  assign w_room     = (int'(w_fifo_count) <= ROOM_LIMIT);

  sync_fifo #(
    .WIDTH (MEM_DATA_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (w_restart),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (bus.rd_data),
    .i_rd_en   (w_xfer),
    .o_rd_data (w_fifo_data),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.rd_burst_len = BURST_BL;
  assign bus.out_valid    = !w_fifo_empty;
  assign bus.out_data     = w_fifo_data;
  assign bus.out_sof      = !w_fifo_empty && (r_x_out == '0) && (r_y_out == '0);
  assign bus.out_eol      = !w_fifo_empty && (r_x_out == LAST_X);
  assign o_underrun       = r_underrun;
  assign o_error          = r_error;
  assign o_state          = r_state;

  // Request-side control: buffer selection, burst issue and beat accounting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_rd_valid     <= 1'b0;
      r_rd_addr      <= '0;
      r_base         <= '0;
      r_req_words    <= '0;
      r_beat_cnt     <= '0;
      r_restart_pend <= 1'b0;
      r_error        <= 1'b0;
    end else if (w_restart) begin
      // The flag names the buffer being written next, so read the other one
      r_base         <= i_image_addr_flag ? ADDR_LEN'(BUF1_BASE) : ADDR_LEN'(BUF0_BASE);
      r_req_words    <= '0;
      r_beat_cnt     <= '0;
      r_restart_pend <= 1'b0;
      r_error        <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_state        <= ARM;
    end else begin
      case (r_state)
        IDLE: r_state <= IDLE;
        ARM: begin
          if (w_room) begin
            r_rd_addr  <= r_base + ADDR_LEN'(r_req_words);
            r_rd_valid <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: r_state <= BURST;
        BURST: begin
          if (i_frame_start) r_restart_pend <= 1'b1;
          if (bus.rd_ready) begin
            if (r_beat_cnt >= BURST_BL) r_error <= 1'b1;
            else                        r_beat_cnt <= r_beat_cnt + 1'b1;
          end
          if (bus.rd_burst_finish) begin
            r_rd_valid  <= 1'b0;
            r_beat_cnt  <= '0;
            r_req_words <= r_req_words + BURST_CNT;
            r_state     <= (r_req_words + BURST_CNT == FRAME_CNT) ? DRAIN : ARM;
          end
        end
        DRAIN: if (r_out_words == FRAME_CNT) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output-side raster position, word count and underrun detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_words <= '0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_underrun  <= 1'b0;
    end else if (w_restart) begin
      r_out_words <= '0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_words <= r_out_words + 1'b1;
        if (r_x_out == LAST_X) begin
          r_x_out <= '0;
          r_y_out <= (r_y_out == LAST_Y) ? '0 : r_y_out + 1'b1;
        end else begin
          r_x_out <= r_x_out + 1'b1;
        end
      end
      if (bus.out_ready && w_fifo_empty && (r_state != IDLE) && (r_out_words < FRAME_CNT))
        r_underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader on a reduced 64x4 frame: a burst memory model, a
// consumer with selectable ready behaviour, and a scoreboard of expected
// output words filled when each frame is started.
module tb_frame_reader;
  import frame_reader_pkg::*;

  localparam int VW    = 64;
  localparam int VH    = 4;
  localparam int BL    = 16;
  localparam int FD    = 64;
  localparam int FRAME = VW * VH;
  localparam int EW    = 66;  // {sof, eol, data}

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   flag = 1'b0;
  logic   fstart = 1'b0;
  logic   underrun;
  logic   error;
  state_t state;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   req_log[$];
  int mem_beats = 16;
  int mem_beat_cnt = 0;
  int ready_mode = 0;  // 0: never ready, 1: always ready, 2: ready only with data
  int n_out = 0;
  int n_sof = 0;
  int n_eol = 0;

  always #5 clk = ~clk;

  frame_reader_if #(.MEM_DATA_LEN(64), .ADDR_LEN(32)) bus ();

  frame_reader #(
    .MEM_DATA_LEN (64),
    .ADDR_LEN     (32),
    .VIDEO_WIDTH  (VW),
    .VIDEO_HEIGHT (VH),
    .BURST_LEN    (BL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_image_addr_flag (flag),
    .i_frame_start     (fstart),
    .bus               (bus),
    .o_underrun        (underrun),
    .o_error           (error),
    .o_state           (state)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Memory model: one cycle of latency, then mem_beats back-to-back beats,
  // then a finish pulse.
  initial begin : mem_model
    logic [31:0] a;
    bus.rd_ready = 1'b0;
    bus.rd_data = '0;
    bus.rd_burst_finish = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst && bus.rd_valid) begin
        a = bus.rd_addr;
        req_log.push_back(a);
        @(posedge clk); #1;
        for (int b = 0; b < mem_beats; b++) begin
          bus.rd_ready = 1'b1;
          bus.rd_data = mem_word(a + 32'(b));
          mem_beat_cnt++;
          @(posedge clk); #1;
        end
        bus.rd_ready = 1'b0;
        bus.rd_burst_finish = 1'b1;
        @(posedge clk); #1;
        bus.rd_burst_finish = 1'b0;
      end
    end
  end

  // Consumer ready driver
  initial begin : consumer
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = (ready_mode == 1) || ((ready_mode == 2) && bus.out_valid);
    end
  end

  // Output monitor and scoreboard compare
  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid && bus.out_ready) begin
        n_out++;
        if (bus.out_sof) n_sof++;
        if (bus.out_eol) n_eol++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_word_unexpected: got %0h, expected no word", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_sof, bus.out_eol, bus.out_data} !== e) begin
            failures++;
            $display("FAIL out_word: got sof=%0b eol=%0b data=%0h, expected sof=%0b eol=%0b data=%0h",
                     bus.out_sof, bus.out_eol, bus.out_data, e[65], e[64], e[63:0]);
          end
        end
      end
    end
  end

  // Pulse frame_start for one cycle and queue the words the frame must produce
  task automatic start_frame(input logic flag_v);
    logic [31:0] base;
    @(posedge clk); #1;
    flag = flag_v;
    fstart = 1'b1;
    base = flag_v ? BUF1_BASE : BUF0_BASE;
    exp_q.delete();
    req_log.delete();
    n_out = 0; n_sof = 0; n_eol = 0;
    for (int i = 0; i < FRAME; i++)
      exp_q.push_back({(i == 0), ((i % VW) == VW - 1), mem_word(base + 32'(i))});
    @(posedge clk); #1;
    fstart = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    for (c = 0; c < budget && !(exp_q.size() == 0 && state == IDLE); c++) @(negedge clk);
    checks++;
    if (!(exp_q.size() == 0 && state == IDLE)) begin
      failures++;
      $display("FAIL frame_done_timeout: %0d words outstanding, state %0d, expected 0 and IDLE",
               exp_q.size(), state);
    end
  endtask

  task automatic test_reset();
    ready_mode = 1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %0b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_addr !== 32'd0) begin failures++; $display("FAIL reset_rd_addr: got %0h expected 0", bus.rd_addr); end
    checks++; if (bus.rd_burst_len !== 10'd16) begin failures++; $display("FAIL reset_burst_len: got %0d expected 16", bus.rd_burst_len); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 64'd0) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
    checks++; if ({bus.out_sof, bus.out_eol} !== 2'b00) begin failures++; $display("FAIL reset_sof_eol: got %0b expected 00", {bus.out_sof, bus.out_eol}); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %0b expected 0", underrun); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %0b expected 0", error); end
    checks++; if (state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected IDLE", state); end
    ready_mode = 0;
  endtask

  task automatic test_first_request();
    ready_mode = 2;
    start_frame(1'b0);
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL req_early: rd_valid got %0b expected 0", bus.rd_valid); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL req_latency: rd_valid got %0b expected 1", bus.rd_valid); end
    checks++; if (bus.rd_addr !== BUF0_BASE) begin failures++; $display("FAIL req_addr_buf0: got %0d expected %0d", bus.rd_addr, BUF0_BASE); end
    checks++; if (bus.rd_burst_len !== 10'd16) begin failures++; $display("FAIL req_burst_len: got %0d expected 16", bus.rd_burst_len); end
    wait_done(3000);
    checks++; if (n_out != FRAME) begin failures++; $display("FAIL frame_words: got %0d expected %0d", n_out, FRAME); end
    checks++; if (n_sof != 1) begin failures++; $display("FAIL frame_sof_count: got %0d expected 1", n_sof); end
    checks++; if (n_eol != VH) begin failures++; $display("FAIL frame_eol_count: got %0d expected %0d", n_eol, VH); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL no_underrun: got %0b expected 0", underrun); end
  endtask

  task automatic test_flag1_addr();
    ready_mode = 1;
    start_frame(1'b1);
    wait_done(3000);
    checks++; if (req_log.size() != FRAME / BL) begin failures++; $display("FAIL burst_count: got %0d expected %0d", req_log.size(), FRAME / BL); end
    if (req_log.size() >= 2) begin
      checks++; if (req_log[0] !== BUF1_BASE) begin failures++; $display("FAIL addr_buf1_first: got %0d expected %0d", req_log[0], BUF1_BASE); end
      checks++; if (req_log[1] !== BUF1_BASE + 32'd16) begin failures++; $display("FAIL addr_buf1_second: got %0d expected %0d", req_log[1], BUF1_BASE + 32'd16); end
    end
    checks++; if (n_out != FRAME) begin failures++; $display("FAIL frame_words_flag1: got %0d expected %0d", n_out, FRAME); end
    // The consumer is ready before the first burst lands, so underrun must latch
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set: got %0b expected 1", underrun); end
  endtask

  task automatic test_backpressure();
    ready_mode = 0;
    start_frame(1'b0);
    @(negedge clk);
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_cleared: got %0b expected 0", underrun); end
    repeat (200) @(negedge clk);
    checks++; if (req_log.size() != FD / BL) begin failures++; $display("FAIL stall_requests: got %0d expected %0d", req_log.size(), FD / BL); end
    checks++; if (n_out != 0) begin failures++; $display("FAIL stall_no_output: got %0d expected 0", n_out); end
    ready_mode = 1;
    wait_done(3000);
    checks++; if (n_out != FRAME) begin failures++; $display("FAIL resume_words: got %0d expected %0d", n_out, FRAME); end
  endtask

  task automatic test_restart_mid_burst();
    int c0;
    ready_mode = 0;
    start_frame(1'b0);
    c0 = mem_beat_cnt;
    for (int c = 0; c < 100 && (mem_beat_cnt - c0) < 5; c++) @(negedge clk);
    start_frame(1'b1);
    for (int c = 0; c < 100 && req_log.size() == 0; c++) @(negedge clk);
    checks++;
    if (req_log.size() == 0) begin
      failures++; $display("FAIL restart_request_timeout: got no request, expected one");
    end else if (req_log[0] !== BUF1_BASE) begin
      failures++; $display("FAIL restart_addr: got %0d expected %0d", req_log[0], BUF1_BASE);
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL restart_flushed: out_valid got %0b expected 0", bus.out_valid); end
    ready_mode = 1;
    wait_done(3000);
    checks++; if (n_out != FRAME) begin failures++; $display("FAIL restart_words: got %0d expected %0d", n_out, FRAME); end
  endtask

  task automatic test_extra_beat();
    ready_mode = 0;
    mem_beats = 17;
    start_frame(1'b0);
    repeat (200) @(negedge clk);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL extra_beat_error: got %0b expected 1", error); end
    // Four bursts fit only if each stored exactly 16 words
    checks++; if (req_log.size() != FD / BL) begin failures++; $display("FAIL extra_beat_fill: got %0d bursts expected %0d", req_log.size(), FD / BL); end
    mem_beats = 16;
    ready_mode = 1;
    wait_done(3000);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL error_sticky: got %0b expected 1", error); end
    start_frame(1'b0);
    @(negedge clk);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL error_cleared: got %0b expected 0", error); end
    wait_done(3000);
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_flag1_addr();
    test_backpressure();
    test_restart_mid_burst();
    test_extra_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
